// File: rtl/demorgan_checker.sv
// Clocked De Morgan evaluator with an exhaustive self-test sweep over every {A,B} pair.
// External operands are evaluated in IDLE; a sweep counts vectors where the identities disagree.
module demorgan_checker #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               fault_inj,
  output logic               out_valid,
  output logic [WIDTH-1:0]   nAandB,
  output logic [WIDTH-1:0]   nAornB,
  output logic [WIDTH-1:0]   nAorB,
  output logic [WIDTH-1:0]   nAandnB,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count
);

  localparam int VW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} StateT;

  StateT            state;
  StateT            stateNext;
  logic [VW-1:0]    vec;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] faultMask;
  logic [WIDTH-1:0] resNand;
  logic [WIDTH-1:0] resNornB;
  logic [WIDTH-1:0] resNor;
  logic [WIDTH-1:0] resNandnB;
  logic             vecFail;
  logic             lastVec;
  logic [VW:0]      errNext;

  // Operands come from the sweep counter while sweeping, otherwise from the ports.
  always_comb begin
    opA          = (state == SWEEP) ? vec[VW-1:WIDTH] : a_in;
    opB          = (state == SWEEP) ? vec[WIDTH-1:0]  : b_in;
    faultMask    = '0;
    faultMask[0] = fault_inj;
    resNand      = ~(opA & opB);
    resNornB     = (~opA | ~opB) ^ faultMask;
    resNor       = ~(opA | opB);
    resNandnB    = ~opA & ~opB;
    vecFail      = (|(resNand ^ resNornB)) || (|(resNor ^ resNandnB));
    lastVec      = &vec;
    errNext      = err_count + {{VW{1'b0}}, vecFail};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = SWEEP;
      SWEEP:   if (lastVec) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SWEEP);
    done = (state == DONE);
  end

  // Datapath: start outranks in_valid; the verdict uses the count including the final vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec       <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      out_valid <= 1'b0;
      nAandB    <= '0;
      nAornB    <= '0;
      nAorB     <= '0;
      nAandnB   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            err_count <= '0;
            pass      <= 1'b0;
          end else if (in_valid) begin
            nAandB    <= resNand;
            nAornB    <= resNornB;
            nAorB     <= resNor;
            nAandnB   <= resNandnB;
            out_valid <= 1'b1;
          end
        end
        SWEEP: begin
          nAandB    <= resNand;
          nAornB    <= resNornB;
          nAorB     <= resNor;
          nAandnB   <= resNandnB;
          vec       <= vec + {{(VW-1){1'b0}}, 1'b1};
          err_count <= errNext;
          if (lastVec) pass <= (errNext == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
